// File: rtl/core_lsu_pkg.sv
// Shared types and address-decode helpers for the core load/store unit.
// Used by core_lsu_mmio and core_lsu_inbuf.
package core_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        IO_RD,
        IO_WR,
        RESP
    } lsu_state_e;

    // The I/O channels occupy the top num_io word addresses.
    function automatic int unsigned io_base(input int unsigned aw, input int unsigned num_io);
        return (32'd1 << aw) - num_io;
    endfunction

    function automatic logic is_io(input logic [31:0] addr, input int unsigned aw,
                                   input int unsigned num_io);
        return addr >= io_base(aw, num_io);
    endfunction

endpackage

// File: rtl/core_lsu_inbuf.sv
// One-entry input buffer for a single I/O stream channel.
// It is instantiated only when CORE_LSU_INBUF_EN is defined.
module core_lsu_inbuf
    import core_lsu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_val_i,
    output logic          in_rdy_o,
    input  logic [DW-1:0] in_data_i,
    output logic          full_o,
    output logic [DW-1:0] data_o,
    input  logic          pop_i
);

    logic          full;
    logic [DW-1:0] data;

    assign in_rdy_o = ~full;
    assign full_o   = full;
    assign data_o   = data;

    // A fill can only happen while empty and a pop only matters while full,
    // so the two never compete for the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full <= 1'b0;
        end else if (in_val_i && !full) begin
            full <= 1'b1;
        end else if (pop_i) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload is qualified by full, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (in_val_i && !full) begin
            data <= in_data_i;
        end
    end

endmodule

// File: rtl/core_lsu_mmio.sv
// Load/store unit with memory-mapped stream I/O on the top NUM_IO word addresses.
// Defining CORE_LSU_INBUF_EN adds a one-entry input buffer per channel.
module core_lsu_mmio
    import core_lsu_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int NUM_IO = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_val_i,
    output logic                 req_rdy_o,
    input  logic                 req_wen_i,
    input  logic [AW-1:0]        req_addr_i,
    input  logic [DW-1:0]        req_data_i,
    output logic                 resp_val_o,
    output logic [DW-1:0]        resp_data_o,
    output logic                 mem_val_o,
    input  logic                 mem_rdy_i,
    output logic                 mem_wen_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [DW-1:0]        mem_rdata_i,
    input  logic [NUM_IO-1:0]    in_val_i,
    output logic [NUM_IO-1:0]    in_rdy_o,
    input  logic [NUM_IO*DW-1:0] in_data_i,
    output logic [NUM_IO-1:0]    out_val_o,
    input  logic [NUM_IO-1:0]    out_rdy_i,
    output logic [DW-1:0]        out_data_o
);

    localparam int            CW      = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [AW-1:0] IO_BASE = AW'(io_base(AW, NUM_IO));

    lsu_state_e        state;
    logic              wen_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     data_q;
    logic [DW-1:0]     result_q;
    logic [CW-1:0]     ch_q;
    logic [NUM_IO-1:0] ch_onehot;
    logic              io_avail;
    logic [DW-1:0]     io_data;

    assign ch_onehot = NUM_IO'(1) << ch_q;

`ifdef CORE_LSU_INBUF_EN
    logic [NUM_IO-1:0]    full;
    logic [NUM_IO*DW-1:0] buf_data;

    for (genvar c = 0; c < NUM_IO; c++) begin : g_inbuf
        core_lsu_inbuf #(.DW(DW)) u_inbuf (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .in_val_i (in_val_i[c]),
            .in_rdy_o (in_rdy_o[c]),
            .in_data_i(in_data_i[c*DW +: DW]),
            .full_o   (full[c]),
            .data_o   (buf_data[c*DW +: DW]),
            .pop_i    (state == IO_RD && ch_q == CW'(c))
        );
    end

    assign io_avail = full[ch_q];
    assign io_data  = buf_data[ch_q*DW +: DW];
`else
    assign in_rdy_o = (state == IO_RD) ? ch_onehot : '0;
    assign io_avail = in_val_i[ch_q];
    assign io_data  = in_data_i[ch_q*DW +: DW];
`endif

    // NOTE: outputs are pure decodes of registered state, so they carry no
    // combinational path from any input and need no hold logic.
    assign req_rdy_o   = (state == IDLE);
    assign resp_val_o  = (state == RESP);
    assign resp_data_o = resp_val_o ? result_q : '0;
    assign mem_val_o   = (state == MEM_REQ);
    assign mem_wen_o   = mem_val_o & wen_q;
    assign mem_addr_o  = mem_val_o ? addr_q : '0;
    assign mem_wdata_o = mem_val_o ? data_q : '0;
    assign out_val_o   = (state == IO_WR) ? ch_onehot : '0;
    assign out_data_o  = (state == IO_WR) ? data_q : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            ch_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val_i) begin
                        wen_q  <= req_wen_i;
                        addr_q <= req_addr_i;
                        data_q <= req_data_i;
                        ch_q   <= CW'(req_addr_i - IO_BASE);
                        if (is_io(32'(req_addr_i), AW, NUM_IO)) begin
                            state <= req_wen_i ? IO_WR : IO_RD;
                        end else begin
                            state <= MEM_REQ;
                        end
                    end
                end
                // Read data is only accepted once the request phase has closed.
                MEM_REQ: begin
                    if (mem_rdy_i) begin
                        if (wen_q) begin
                            result_q <= '0;
                            state    <= RESP;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        result_q <= mem_rdata_i;
                        state    <= RESP;
                    end
                end
                IO_RD: begin
                    if (io_avail) begin
                        result_q <= io_data;
                        state    <= RESP;
                    end
                end
                IO_WR: begin
                    if (out_rdy_i[ch_q]) begin
                        result_q <= '0;
                        state    <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu_mmio.sv
// Directed and randomised checks of core_lsu_mmio with two I/O channels (0xFE, 0xFF).
// Expectations adapt when CORE_LSU_INBUF_EN is defined.
module tb_core_lsu_mmio;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int NIO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              req_val, req_rdy, req_wen;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_data;
    logic              resp_val;
    logic [DW-1:0]     resp_data;
    logic              mem_val, mem_rdy, mem_wen;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;
    logic [NIO-1:0]    in_val, in_rdy;
    logic [NIO*DW-1:0] in_data;
    logic [NIO-1:0]    out_val, out_rdy;
    logic [DW-1:0]     out_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] ref_mem [256];

    core_lsu_mmio #(.AW(AW), .DW(DW), .NUM_IO(NIO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_val_i   (req_val),
        .req_rdy_o   (req_rdy),
        .req_wen_i   (req_wen),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .resp_val_o  (resp_val),
        .resp_data_o (resp_data),
        .mem_val_o   (mem_val),
        .mem_rdy_i   (mem_rdy),
        .mem_wen_o   (mem_wen),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata),
        .in_val_i    (in_val),
        .in_rdy_o    (in_rdy),
        .in_data_i   (in_data),
        .out_val_o   (out_val),
        .out_rdy_i   (out_rdy),
        .out_data_o  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int budget);
        int n = 0;
        while (!resp_val && n < budget) begin
            tick();
            n++;
        end
        chk("resp_within_budget", 32'(resp_val), 32'd1);
    endtask

    // One transaction with randomised memory / stream handshakes; returns
    // during its RESP cycle so the next call issues back-to-back.
    task automatic do_op(input logic wen, input logic [7:0] addr, input logic [15:0] data);
        logic          io       = (addr >= 8'hFE);
        int            ch       = io ? int'(addr) - 254 : 0;
        logic [1:0]    oh       = 2'b01 << ch;
        logic [15:0]   in_word  = 16'($urandom);
        int            in_cnt   = int'($urandom_range(0, 3));
        logic [15:0]   exp;
        logic          accepted = 1'b0;
        logic          done     = 1'b0;
        int            rd_cnt   = 0;
        logic [7:0]    raddr    = '0;
        logic          acc_now, mem_hs, in_hs, out_hs, snap_wen;
        logic [7:0]    snap_addr;
        logic [15:0]   snap_wdata, snap_out;
        logic [1:0]    snap_oval;

        if (wen) begin
            exp = '0;
            if (!io) ref_mem[addr] = data;
        end else begin
            exp = io ? in_word : ref_mem[addr];
        end
        req_val  = 1'b1;
        req_wen  = wen;
        req_addr = addr;
        req_data = data;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (accepted && resp_val) begin
                chk("rnd_resp_data", 32'(resp_data), 32'(exp));
                chk("rnd_no_accept_in_resp", 32'(req_rdy), 32'd0);
                done = 1'b1;
            end else begin
                mem_rdy    = mem_val ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rvalid = (rd_cnt == 1);
                mem_rdata  = (rd_cnt == 1) ? mem_arr[raddr] : 16'h0;
                if (rd_cnt > 0) rd_cnt--;
                if (accepted && io && !wen) begin
                    in_data = {16'hA5A5, 16'hA5A5};
                    in_data[ch*16 +: 16] = in_word;
                    if (in_cnt == 0) in_val = oh;
                    else in_cnt--;
                end
                out_rdy    = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                acc_now    = req_val && req_rdy;
                mem_hs     = mem_val && mem_rdy;
                in_hs      = (in_val & in_rdy) != 2'b00;
                out_hs     = (out_val & out_rdy) != 2'b00;
                snap_wen   = mem_wen;
                snap_addr  = mem_addr;
                snap_wdata = mem_wdata;
                snap_oval  = out_val;
                snap_out   = out_data;
                tick();
                if (acc_now) begin
                    accepted = 1'b1;
                    req_val  = 1'b0;
                end
                if (mem_hs) begin
                    chk("rnd_mem_addr", 32'(snap_addr), 32'(addr));
                    if (snap_wen) begin
                        chk("rnd_mem_wdata", 32'(snap_wdata), 32'(data));
                        mem_arr[snap_addr] = snap_wdata;
                    end else begin
                        rd_cnt = int'($urandom_range(1, 3));
                        raddr  = snap_addr;
                    end
                end
                if (in_hs) in_val = '0;
                if (out_hs) begin
                    chk("rnd_out_val", 32'(snap_oval), 32'(oh));
                    chk("rnd_out_data", 32'(snap_out), 32'(data));
                end
            end
        end
        if (!done) chk("rnd_resp_timeout", 32'(resp_val), 32'd1);
        req_val    = 1'b0;
        mem_rdy    = 1'b0;
        mem_rvalid = 1'b0;
        in_val     = '0;
        out_rdy    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_val = 1'b0; req_wen = 1'b0; req_addr = '0; req_data = '0;
        mem_rdy = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        in_val = '0; in_data = '0; out_rdy = '0;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 16'(i * 3 + 1);
            ref_mem[i] = 16'(i * 3 + 1);
        end
        tick();
        tick();

        // Reset state
        chk("rst_req_rdy", 32'(req_rdy), 32'd1);
        chk("rst_resp_val", 32'(resp_val), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_mem_val", 32'(mem_val), 32'd0);
        chk("rst_mem_bus", {mem_wen, mem_addr, mem_wdata}, 32'd0);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef CORE_LSU_INBUF_EN
        chk("rst_in_rdy", 32'(in_rdy), 32'd3);
`else
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Load 0x10: rvalid ignored in MEM_REQ, 0xBEEF returned on the following cycle
        req_val = 1'b1; req_wen = 1'b0; req_addr = 8'h10; req_data = '0; mem_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        chk("ld_mem_val", 32'(mem_val), 32'd1);
        chk("ld_mem_addr", 32'(mem_addr), 32'h10);
        chk("ld_mem_wen", 32'(mem_wen), 32'd0);
        chk("ld_req_rdy_busy", 32'(req_rdy), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_rdy = 1'b0; mem_rdata = 16'hBEEF;
        chk("ld_wait_no_resp", 32'(resp_val), 32'd0);
        chk("ld_wait_mem_val", 32'(mem_val), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("ld_resp_val", 32'(resp_val), 32'd1);
        chk("ld_resp_data", 32'(resp_data), 32'hBEEF);
        tick();
        chk("ld_back_idle", {resp_val, req_rdy}, 32'b01);

        // Store 0x1234 to 0x20 with mem_rdy low for 4 cycles
        req_val = 1'b1; req_wen = 1'b1; req_addr = 8'h20; req_data = 16'h1234;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st_hold_bus", {mem_val, mem_wen, 6'd0, mem_addr, mem_wdata}, {2'b11, 6'd0, 8'h20, 16'h1234});
            chk("st_hold_no_resp", 32'(resp_val), 32'd0);
            tick();
        end
        mem_rdy = 1'b1;
        chk("st_val_at_rdy", 32'(mem_val), 32'd1);
        tick();
        mem_rdy = 1'b0;
        chk("st_resp_val", 32'(resp_val), 32'd1);
        chk("st_resp_data", 32'(resp_data), 32'd0);
        chk("st_single_write", 32'(mem_val), 32'd0);
        tick();

        // Store 0x00AA to channel 0 (0xFE) with out_rdy[0] low for 3 cycles
        req_val = 1'b1; req_wen = 1'b1; req_addr = 8'hFE; req_data = 16'h00AA;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("iow_out_val", 32'(out_val), 32'b01);
            chk("iow_out_data", 32'(out_data), 32'h00AA);
            chk("iow_no_mem", 32'(mem_val), 32'd0);
            tick();
        end
        out_rdy = 2'b01;
        tick();
        out_rdy = 2'b00;
        chk("iow_resp", {resp_val, 15'd0, resp_data}, {1'b1, 31'd0});
        chk("iow_out_val_done", 32'(out_val), 32'd0);
        tick();

        // Load channel 1 (0xFF), data arrives 5 cycles later
        req_val = 1'b1; req_wen = 1'b0; req_addr = 8'hFF;
        tick();
        req_val = 1'b0;
`ifdef CORE_LSU_INBUF_EN
        chk("ior_in_rdy", 32'(in_rdy), 32'b11);
`else
        chk("ior_in_rdy", 32'(in_rdy), 32'b10);
`endif
        for (int i = 0; i < 5; i++) begin
            chk("ior_wait_no_resp", 32'(resp_val), 32'd0);
            tick();
        end
        in_val = 2'b10; in_data = 32'h5555_1111;
        tick();
        in_val = 2'b00;
        wait_resp(4);
        chk("ior_resp_data", 32'(resp_data), 32'h5555);
        tick();

`ifdef CORE_LSU_INBUF_EN
        // Pre-filled buffer on channel 1 completes in 2 cycles
        in_val = 2'b10; in_data = 32'h7777_0000;
        tick();
        in_val = 2'b00;
        chk("buf_full_rdy", 32'(in_rdy), 32'b01);
        req_val = 1'b1; req_wen = 1'b0; req_addr = 8'hFF;
        tick();
        req_val = 1'b0;
        tick();
        chk("buf_resp_val", 32'(resp_val), 32'd1);
        chk("buf_resp_data", 32'(resp_data), 32'h7777);
        chk("buf_rdy_after_pop", 32'(in_rdy), 32'b11);
        tick();
`endif

        // Reset while in MEM_WAIT, then a late rvalid, then a normal load
        req_val = 1'b1; req_wen = 1'b0; req_addr = 8'h30; mem_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        tick();
        mem_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstop_no_resp", 32'(resp_val), 32'd0);
        chk("rstop_idle", 32'(req_rdy), 32'd1);
        chk("rstop_mem_val", 32'(mem_val), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 16'hBAD0;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_no_resp", 32'(resp_val), 32'd0);
        chk("late_rvalid_idle", 32'(req_rdy), 32'd1);
        req_val = 1'b1; req_wen = 1'b0; req_addr = 8'h31; mem_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        chk("post_rst_mem_addr", 32'(mem_addr), 32'h31);
        tick();
        mem_rdy = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h4242;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_resp", {resp_val, 15'd0, resp_data}, {1'b1, 15'd0, 16'h4242});
        tick();

        // Back-to-back mixed operations against the reference memory
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       do_op(1'b0, 8'($urandom_range(0, 253)), 16'h0);
                1:       do_op(1'b1, 8'($urandom_range(0, 253)), 16'($urandom));
                2:       do_op(1'b0, 8'(254 + $urandom_range(0, 1)), 16'h0);
                default: do_op(1'b1, 8'(254 + $urandom_range(0, 1)), 16'($urandom));
            endcase
        end
        tick();
        chk("final_idle", 32'(req_rdy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
